// File: rtl/rs_tb_pkg.sv
// Shared constants for the RS bench-side blocks: FSM encoding, position width,
// the default burst-length limit and a saturating increment for position-wide values.
package rs_tb_pkg;
    localparam int POS_W = 17;
    localparam logic [POS_W-1:0] MAX_BURST_DEF = 17'd130560;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/ref_delay_line.sv
// Zero-initialised shift register aligning the clean stream with the dut stream;
// DEPTH=0 is a plain wire.
module ref_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 0
) (
    input  logic             clk_out125M,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_out125M ^ sys_rst;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage;
            always_ff @(posedge clk_out125M) begin
                if (sys_rst) begin
                    stage <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end
            assign dout = stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/error_burst_monitor.sv
// Compares a dut byte stream against its clean reference and reports each byte-error
// burst (start, inclusive length, mismatch count) plus cumulative error statistics.
module error_burst_monitor
    import rs_tb_pkg::*;
#(
    parameter int               REF_DLY   = 0,
    parameter int               GAP_TOL   = 2,
    parameter logic [POS_W-1:0] MAX_BURST = MAX_BURST_DEF
) (
    input  logic             clk_out125M,
    input  logic             sys_rst,
    input  logic [7:0]       ref_data,
    input  logic             ref_sync,
    input  logic [7:0]       dut_data,
    input  logic             dut_sync,
    input  logic             stat_clr,
    output logic             burst_done,
    output logic [POS_W-1:0] burst_start,
    output logic [POS_W-1:0] burst_len,
    output logic [POS_W-1:0] burst_errs,
    output logic [7:0]       burst_cnt,
    output logic [23:0]      err_byte_cnt,
    output logic             len_exceeded,
    output logic [1:0]       state_o
);
    localparam int GAP_W = $clog2(GAP_TOL + 2);

    logic [8:0]       ref_pipe;
    logic [7:0]       ref_d;
    logic             rsync_d;
    logic             cmp_valid;
    logic             mismatch;
    logic [1:0]       state;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] start;
    logic [POS_W-1:0] last;
    logic [POS_W-1:0] errs;
    logic [GAP_W-1:0] gap;
    logic             close;
    logic [POS_W:0]   span;
    logic [POS_W-1:0] span_sat;

    ref_delay_line #(.WIDTH(9), .DEPTH(REF_DLY)) u_ref_dly (
        .clk_out125M (clk_out125M),
        .sys_rst     (sys_rst),
        .din         ({ref_sync, ref_data}),
        .dout        (ref_pipe)
    );

    assign rsync_d   = ref_pipe[8];
    assign ref_d     = ref_pipe[7:0];
    assign cmp_valid = rsync_d & dut_sync;
    assign mismatch  = cmp_valid & (ref_d != dut_data);

    // last >= start always holds, so the span only needs clamping at the top
    assign span     = {1'b0, last} - {1'b0, start} + (POS_W+1)'(1);
    assign span_sat = span[POS_W] ? '1 : span[POS_W-1:0];

    always_comb begin
        close = 1'b0;
        if (state == BURST)
            close = !cmp_valid || (!mismatch && gap == GAP_W'(GAP_TOL));
    end

    always_ff @(posedge clk_out125M) begin
        if (sys_rst || !cmp_valid) pos <= '0;
        else                       pos <= sat_inc(pos);
    end

    always_ff @(posedge clk_out125M) begin
        if (sys_rst) begin
            state <= IDLE;
            start <= '0;
            last  <= '0;
            errs  <= '0;
            gap   <= '0;
        end else begin
            case (state)
                // IDLE and SCAN only differ in name: both open a burst on mismatch
                IDLE, SCAN: begin
                    if (mismatch) begin
                        start <= pos;
                        last  <= pos;
                        errs  <= POS_W'(1);
                        gap   <= '0;
                        state <= BURST;
                    end else if (cmp_valid) begin
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    if (!cmp_valid) begin
                        state <= IDLE;
                    end else if (mismatch) begin
                        last <= pos;
                        errs <= sat_inc(errs);
                        gap  <= '0;
                    end else if (close) begin
                        state <= SCAN;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out125M) begin
        if (sys_rst) begin
            burst_done   <= 1'b0;
            burst_start  <= '0;
            burst_len    <= '0;
            burst_errs   <= '0;
            burst_cnt    <= '0;
            err_byte_cnt <= '0;
            len_exceeded <= 1'b0;
        end else begin
            burst_done <= close;
            if (close) begin
                burst_start <= start;
                burst_len   <= span_sat;
                burst_errs  <= errs;
            end
            if (stat_clr) begin
                burst_cnt    <= '0;
                err_byte_cnt <= '0;
                len_exceeded <= 1'b0;
            end else begin
                if (close && !(&burst_cnt))       burst_cnt    <= burst_cnt + 8'd1;
                if (mismatch && !(&err_byte_cnt)) err_byte_cnt <= err_byte_cnt + 24'd1;
                if (close && span_sat > MAX_BURST) len_exceeded <= 1'b1;
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_error_burst_monitor.sv
// Bench for error_burst_monitor: directed table, hand-written corner sequences and a
// randomized run scored against a position-based burst model.
module tb_error_burst_monitor;
    import rs_tb_pkg::*;

    localparam int GAP_TOL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  r0_data, d0_data, r1_data, d1_data;
    logic        r0_sync, d0_sync, r1_sync, d1_sync, clr0, clr1;
    logic        done0, done1, exc0, exc1;
    logic [16:0] start0, len0, errs0, start1, len1, errs1;
    logic [7:0]  cnt0, cnt1;
    logic [23:0] ebc0, ebc1;
    logic [1:0]  st0, st1;

    always #4 clk = ~clk;

    error_burst_monitor #(.REF_DLY(0), .GAP_TOL(GAP_TOL), .MAX_BURST(17'd64)) u_dut0 (
        .clk_out125M(clk), .sys_rst(rst), .ref_data(r0_data), .ref_sync(r0_sync),
        .dut_data(d0_data), .dut_sync(d0_sync), .stat_clr(clr0), .burst_done(done0),
        .burst_start(start0), .burst_len(len0), .burst_errs(errs0), .burst_cnt(cnt0),
        .err_byte_cnt(ebc0), .len_exceeded(exc0), .state_o(st0));

    error_burst_monitor #(.REF_DLY(3), .GAP_TOL(GAP_TOL)) u_dut1 (
        .clk_out125M(clk), .sys_rst(rst), .ref_data(r1_data), .ref_sync(r1_sync),
        .dut_data(d1_data), .dut_sync(d1_sync), .stat_clr(clr1), .burst_done(done1),
        .burst_start(start1), .burst_len(len1), .burst_errs(errs1), .burst_cnt(cnt1),
        .err_byte_cnt(ebc1), .len_exceeded(exc1), .state_o(st1));

    typedef struct { int cyc; int start; int len; int errs; } ev_t;
    typedef struct { int a; int b; int z; int e_close; int e_start; int e_len; int e_errs; int e_exc; } vec_t;

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    ev_t got[$];
    bit  mm[1024];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // every clock step goes through here; burst reports are captured against the
    // index of the compare cycle that was just clocked
    task automatic tick();
        @(posedge clk);
        #1;
        if (done0) got.push_back('{cyc, int'(start0), int'(len0), int'(errs0)});
        cyc++;
    endtask

    task automatic drv(input bit rs, input bit ds, input logic [7:0] rd, input logic [7:0] dd);
        r0_sync = rs; d0_sync = ds; r0_data = rd; d0_data = dd;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_sync = 1'b0; d0_sync = 1'b0; r0_data = 8'h00; d0_data = 8'h00; clr0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        cyc = 0;
    endtask

    function automatic logic [7:0] pat(input int p);
        return 8'(p % 255 + 1);
    endfunction

    // dut forced to zero over [a,b]; ref is a nonzero counter except 0x00 at z
    task automatic run_win(input int n, input int a, input int b, input int z);
        logic [7:0] rd, dd;
        for (int p = 0; p < n; p++) begin
            rd = (p == z) ? 8'h00 : pat(p);
            dd = (p >= a && p <= b) ? 8'h00 : rd;
            drv(1'b1, 1'b1, rd, dd);
        end
    endtask

    task automatic run_mask(input int n);
        for (int p = 0; p < n; p++) drv(1'b1, 1'b1, pat(p), mm[p] ? ~pat(p) : pat(p));
    endtask

    initial begin
        vec_t vt[5];
        bit   rv[$];
        bit   rm[$];
        ev_t  exp_q[$];
        logic [7:0] hist[$];
        int   n_done1;

        vt[0] = '{457, 556,  -1, 559, 457, 100, 100, 1};
        vt[1] = '{457, 556, 500, 559, 457, 100,  99, 1};
        vt[2] = '{  0,   0,  -1,   3,   0,   1,   1, 0};
        vt[3] = '{ 10,  73,  -1,  76,  10,  64,  64, 0};
        vt[4] = '{ 10,  74,  -1,  77,  10,  65,  65, 1};

        r1_sync = 1'b0; d1_sync = 1'b0; r1_data = 8'h00; d1_data = 8'h00; clr1 = 1'b0;

        // reset state, with mismatching traffic present during reset
        rst = 1'b1; clr0 = 1'b0;
        r0_sync = 1'b1; d0_sync = 1'b1; r0_data = 8'h5A; d0_data = 8'hA5;
        tick(); tick();
        check("rst_done", done0, 0);
        check("rst_start", start0, 0);
        check("rst_len", len0, 0);
        check("rst_errs", errs0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ebc", ebc0, 0);
        check("rst_exc", exc0, 0);
        check("rst_state", st0, IDLE);

        // single-window table
        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_win(vt[i].b + 10, vt[i].a, vt[i].b, vt[i].z);
            check("tbl_ndone", got.size(), 1);
            if (got.size() > 0) begin
                check("tbl_close_cyc", got[0].cyc, vt[i].e_close);
                check("tbl_start", got[0].start, vt[i].e_start);
                check("tbl_len", got[0].len, vt[i].e_len);
                check("tbl_errs", got[0].errs, vt[i].e_errs);
            end
            check("tbl_cnt", cnt0, 1);
            check("tbl_ebc", ebc0, vt[i].e_errs);
            check("tbl_exc", exc0, vt[i].e_exc);
        end

        // mismatches at 10, 13, 20: gap of two stays in the burst, gap of six splits
        do_reset();
        foreach (mm[i]) mm[i] = 1'b0;
        mm[10] = 1'b1; mm[13] = 1'b1; mm[20] = 1'b1;
        run_mask(30);
        check("split_ndone", got.size(), 2);
        if (got.size() == 2) begin
            check("split0_cyc", got[0].cyc, 16);
            check("split0_start", got[0].start, 10);
            check("split0_len", got[0].len, 4);
            check("split0_errs", got[0].errs, 2);
            check("split1_cyc", got[1].cyc, 23);
            check("split1_start", got[1].start, 20);
            check("split1_len", got[1].len, 1);
            check("split1_errs", got[1].errs, 1);
        end
        check("split_cnt", cnt0, 2);
        check("split_ebc", ebc0, 3);

        // back-to-back: new mismatch in the compare cycle right after a close
        do_reset();
        foreach (mm[i]) mm[i] = 1'b0;
        mm[10] = 1'b1; mm[14] = 1'b1;
        run_mask(24);
        check("b2b_ndone", got.size(), 2);
        if (got.size() == 2) begin
            check("b2b_spacing", got[1].cyc - got[0].cyc, GAP_TOL + 2);
            check("b2b_start", got[1].start, 14);
        end

        // sync drop inside a burst; pos restarts at 0 on re-rise
        do_reset();
        for (int p = 0; p < 200; p++) drv(1'b1, 1'b1, pat(p), (p >= 150) ? ~pat(p) : pat(p));
        drv(1'b1, 1'b0, pat(200), pat(200));
        check("drop_done", done0, 1);
        check("drop_start", start0, 150);
        check("drop_len", len0, 50);
        check("drop_errs", errs0, 50);
        check("drop_state", st0, IDLE);
        drv(1'b0, 1'b0, 8'h00, 8'h00);
        check("drop_pulse", done0, 0);
        drv(1'b1, 1'b1, pat(0), ~pat(0));
        drv(1'b1, 1'b0, pat(1), pat(1));
        check("rerise_done", done0, 1);
        check("rerise_start", start0, 0);
        check("rerise_len", len0, 1);

        // reset in mid-burst drops the burst silently
        do_reset();
        for (int p = 0; p < 5; p++) drv(1'b1, 1'b1, pat(p), ~pat(p));
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) drv(1'b0, 1'b0, 8'h00, 8'h00);
        check("midrst_ndone", got.size(), 0);
        check("midrst_cnt", cnt0, 0);

        // 80-byte burst over a limit of 64, then stat_clr coinciding with a mismatch
        do_reset();
        run_win(100, 10, 89, -1);
        check("lim_exc", exc0, 1);
        check("lim_cnt", cnt0, 1);
        check("lim_ebc", ebc0, 80);
        clr0 = 1'b1;
        drv(1'b1, 1'b1, pat(100), ~pat(100));
        clr0 = 1'b0;
        check("clr_ebc", ebc0, 0);
        check("clr_cnt", cnt0, 0);
        check("clr_exc", exc0, 0);
        drv(1'b1, 1'b0, pat(101), pat(101));
        check("clr_burst_kept", done0, 1);
        check("clr_burst_start", start0, 100);
        drv(1'b0, 1'b0, 8'h00, 8'h00);
        check("clr_cnt_after", cnt0, 1);

        // REF_DLY=3: dut carries the reference delayed by three cycles, uncorrupted
        rst = 1'b1; d1_sync = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_done1 = 0;
        for (int k = 0; k < 200; k++) begin
            r1_sync = 1'b1;
            r1_data = 8'($urandom);
            hist.push_back(r1_data);
            d1_data = (k < 3) ? 8'h00 : hist[k-3];
            tick();
            if (done1) n_done1++;
            if (k == 2) check("dly_state_idle", st1, IDLE);
            if (k == 3) check("dly_state_scan", st1, SCAN);
        end
        check("dly_ndone", n_done1, 0);
        check("dly_ebc", ebc1, 0);

        // randomized traffic with sync drops and error density varying in blocks
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rs, ds, mis;
            int thr;
            logic [7:0] rd;
            thr = ((i / 500) % 3 == 0) ? 2 : ((i / 500) % 3 == 1) ? 10 : 35;
            rs  = $urandom_range(0, 99) >= 3;
            ds  = $urandom_range(0, 99) >= 2;
            mis = $urandom_range(0, 99) < thr;
            rd  = 8'($urandom);
            rv.push_back(rs & ds);
            rm.push_back(rs & ds & mis);
            drv(rs, ds, rd, mis ? (rd ^ 8'($urandom_range(1, 255))) : rd);
        end
        for (int i = 0; i < 4; i++) begin
            rv.push_back(1'b0);
            rm.push_back(1'b0);
            drv(1'b0, 1'b0, 8'h00, 8'h00);
        end

        // model: a burst groups mismatches within one sync segment whose positions are
        // at most GAP_TOL+1 apart; it ends at the segment end or GAP_TOL+1 clean positions
        begin
            int p, st, last, errs, tot;
            bit open;
            p = 0; st = 0; last = 0; errs = 0; tot = 0; open = 1'b0;
            for (int t = 0; t < rv.size(); t++) begin
                if (!rv[t]) begin
                    if (open) exp_q.push_back('{t, st, last - st + 1, errs});
                    open = 1'b0;
                    p = 0;
                end else begin
                    if (rm[t]) begin
                        tot++;
                        if (open) begin
                            last = p;
                            errs++;
                        end else begin
                            open = 1'b1; st = p; last = p; errs = 1;
                        end
                    end else if (open && p - last == GAP_TOL + 1) begin
                        exp_q.push_back('{t, st, last - st + 1, errs});
                        open = 1'b0;
                    end
                    p++;
                end
            end
            check("rand_nbursts", got.size(), exp_q.size());
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                check("rand_cyc", got[i].cyc, exp_q[i].cyc);
                check("rand_start", got[i].start, exp_q[i].start);
                check("rand_len", got[i].len, exp_q[i].len);
                check("rand_errs", got[i].errs, exp_q[i].errs);
            end
            check("rand_ebc", ebc0, tot);
            check("rand_cnt", cnt0, (exp_q.size() > 255) ? 255 : exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
